// File: rtl/apb_pkg.sv
// Shared types and defaults for the APB master: FSM state encoding and
// default widths/timeout.
package apb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_state_t;

   localparam int APB_ADDR_WIDTH_DEF = 32;
   localparam int APB_DATA_WIDTH_DEF = 32;
   localparam int APB_TIMEOUT_DEF    = 16;

   // Counter width able to hold the value TIMEOUT_CYCLES itself.
   function automatic int timeout_cnt_width(input int timeout_cycles);
      return $clog2(timeout_cycles + 1);
   endfunction

endpackage

// File: rtl/apb_master_if.sv
// APB bus bundle between the master and a single slave.
interface apb_master_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                  o_psel;
   logic                  o_penable;
   logic                  o_pwrite;
   logic [ADDR_WIDTH-1:0] o_paddr;
   logic [DATA_WIDTH-1:0] o_pwdata;
   logic                  i_pready;
   logic                  i_pslverr;
   logic [DATA_WIDTH-1:0] i_prdata;

   modport master (
      output o_psel, o_penable, o_pwrite, o_paddr, o_pwdata,
      input  i_pready, i_pslverr, i_prdata
   );

   modport slave (
      input  o_psel, o_penable, o_pwrite, o_paddr, o_pwdata,
      output i_pready, i_pslverr, i_prdata
   );
endinterface

// File: rtl/apb_timeout_cnt.sv
// ACCESS wait-state counter; expired flags when the count reaches the limit.
module apb_timeout_cnt #(
   parameter int CNT_W = 5
) (
   input  logic             i_clk_apb,
   input  logic             i_rstn_apb,
   input  logic             i_clear,
   input  logic             i_enable,
   input  logic [CNT_W-1:0] i_limit,
   output logic             o_expired
);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge i_clk_apb or negedge i_rstn_apb) begin
      if (!i_rstn_apb)                r_cnt <= '0;
      else if (i_clear)               r_cnt <= '0;
      else if (i_enable && !o_expired) r_cnt <= r_cnt + 1'b1;
   end

   assign o_expired = (r_cnt == i_limit);

endmodule

// File: rtl/apb_master.sv
// Single-outstanding APB master: upstream valid/ready request in, APB
// SETUP/ACCESS sequence out, registered one-cycle completion status back.
module apb_master
   import apb_pkg::*;
#(
   parameter int ADDR_WIDTH     = APB_ADDR_WIDTH_DEF,
   parameter int DATA_WIDTH     = APB_DATA_WIDTH_DEF,
   parameter int TIMEOUT_CYCLES = APB_TIMEOUT_DEF
) (
   input  logic                  i_clk_apb,
   input  logic                  i_rstn_apb,
   input  logic                  i_valid,
   output logic                  o_ready,
   input  logic [ADDR_WIDTH-1:0] i_addr,
   input  logic                  i_rd0_wr1,
   input  logic [DATA_WIDTH-1:0] i_wr_data,
   output logic                  o_done,
   output logic                  o_rd_valid,
   output logic [DATA_WIDTH-1:0] o_rd_data,
   output logic                  o_err,
   apb_master_if.master          m_apb
);

   localparam int CNT_W = timeout_cnt_width(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

   apb_state_t r_state, w_state_nxt;

   logic                  r_pwrite;
   logic [ADDR_WIDTH-1:0] r_paddr;
   logic [DATA_WIDTH-1:0] r_pwdata;
   logic                  r_done, r_rd_valid, r_err;
   logic [DATA_WIDTH-1:0] r_rd_data;

   logic w_accept, w_finish, w_cnt_en, w_expired;
   logic w_psel, w_penable, w_ready;

   apb_timeout_cnt #(.CNT_W(CNT_W)) u_timeout (
      .i_clk_apb  (i_clk_apb),
      .i_rstn_apb (i_rstn_apb),
      .i_clear    (w_accept),
      .i_enable   (w_cnt_en),
      .i_limit    (CNT_LIMIT),
      .o_expired  (w_expired)
   );

   always_ff @(posedge i_clk_apb or negedge i_rstn_apb) begin
      if (!i_rstn_apb) r_state <= IDLE;
      else             r_state <= w_state_nxt;
   end

   // APB strobes decode straight from state so reset drops them at once.
   always_comb begin
      w_state_nxt = r_state;
      w_ready     = 1'b0;
      w_psel      = 1'b0;
      w_penable   = 1'b0;
      w_accept    = 1'b0;
      w_finish    = 1'b0;
      w_cnt_en    = 1'b0;
      case (r_state)
         IDLE: begin
            w_ready = 1'b1;
            if (i_valid) begin
               w_accept    = 1'b1;
               w_state_nxt = SETUP;
            end
         end
         SETUP: begin
            w_psel      = 1'b1;
            w_state_nxt = ACCESS;
         end
         ACCESS: begin
            w_psel    = 1'b1;
            w_penable = 1'b1;
            if (m_apb.i_pready || w_expired) begin
               w_finish    = 1'b1;
               w_state_nxt = IDLE;
            end else begin
               w_cnt_en = 1'b1;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_clk_apb or negedge i_rstn_apb) begin
      if (!i_rstn_apb) begin
         r_pwrite   <= 1'b0;
         r_paddr    <= '0;
         r_pwdata   <= '0;
         r_done     <= 1'b0;
         r_rd_valid <= 1'b0;
         r_err      <= 1'b0;
         r_rd_data  <= '0;
      end else begin
         if (w_accept) begin
            r_paddr  <= i_addr;
            r_pwrite <= i_rd0_wr1;
            r_pwdata <= i_wr_data;
         end
         r_done     <= w_finish;
         r_rd_valid <= w_finish & ~r_pwrite;
         r_err      <= 1'b0;
         // pready beats a same-cycle timeout; a timeout reports error, no data.
         if (w_finish) begin
            r_err     <= m_apb.i_pready ? m_apb.i_pslverr : 1'b1;
            r_rd_data <= (m_apb.i_pready && !r_pwrite) ? m_apb.i_prdata : '0;
         end
      end
   end

   assign o_ready         = w_ready;
   assign o_done          = r_done;
   assign o_rd_valid      = r_rd_valid;
   assign o_err           = r_err;
   assign o_rd_data       = r_rd_data;
   assign m_apb.o_psel    = w_psel;
   assign m_apb.o_penable = w_penable;
   assign m_apb.o_pwrite  = r_pwrite;
   assign m_apb.o_paddr   = r_paddr;
   assign m_apb.o_pwdata  = r_pwdata;

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master with TIMEOUT_CYCLES=4; inputs driven and
// outputs sampled on the falling edge.
module tb_apb_master;

   localparam int AW = 32;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          i_valid = 1'b0;
   logic          o_ready;
   logic [AW-1:0] i_addr = '0;
   logic          i_rd0_wr1 = 1'b0;
   logic [DW-1:0] i_wr_data = '0;
   logic          o_done, o_rd_valid, o_err;
   logic [DW-1:0] o_rd_data;

   int n_chk = 0;
   int n_err = 0;

   apb_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) apb ();

   apb_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(4)) dut (
      .i_clk_apb  (clk),
      .i_rstn_apb (rst_n),
      .i_valid    (i_valid),
      .o_ready    (o_ready),
      .i_addr     (i_addr),
      .i_rd0_wr1  (i_rd0_wr1),
      .i_wr_data  (i_wr_data),
      .o_done     (o_done),
      .o_rd_valid (o_rd_valid),
      .o_rd_data  (o_rd_data),
      .o_err      (o_err),
      .m_apb      (apb)
   );

   always #5 clk = ~clk;

   task automatic request(input logic [AW-1:0] a, input logic wr, input logic [DW-1:0] d);
      i_valid   = 1'b1;
      i_addr    = a;
      i_rd0_wr1 = wr;
      i_wr_data = d;
   endtask

   task automatic test_reset();
      apb.i_pready = 1'b0; apb.i_pslverr = 1'b0; apb.i_prdata = '0;
      repeat (2) @(negedge clk);
      n_chk++; if (apb.o_psel !== 1'b0) begin n_err++; $display("FAIL rst_psel: got %b want 0", apb.o_psel); end
      n_chk++; if (apb.o_penable !== 1'b0) begin n_err++; $display("FAIL rst_penable: got %b want 0", apb.o_penable); end
      n_chk++; if (o_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %b want 1", o_ready); end
      n_chk++; if ({o_done, o_rd_valid, o_err} !== 3'b000) begin n_err++; $display("FAIL rst_status: got %b want 000", {o_done, o_rd_valid, o_err}); end
      n_chk++; if (apb.o_paddr !== 32'h0 || apb.o_pwdata !== 32'h0 || apb.o_pwrite !== 1'b0) begin n_err++; $display("FAIL rst_bus: got %h/%h/%b want 0/0/0", apb.o_paddr, apb.o_pwdata, apb.o_pwrite); end
      n_chk++; if (o_rd_data !== 32'h0) begin n_err++; $display("FAIL rst_rd_data: got %h want 0", o_rd_data); end
      rst_n = 1'b1;
   endtask

   task automatic test_write_ok();
      @(negedge clk); request(32'h0000_0010, 1'b1, 32'hDEAD_BEEF);
      @(negedge clk); i_valid = 1'b0;
      n_chk++; if ({apb.o_psel, apb.o_penable} !== 2'b10) begin n_err++; $display("FAIL wr_setup: got %b want 10", {apb.o_psel, apb.o_penable}); end
      n_chk++; if (apb.o_paddr !== 32'h10 || apb.o_pwdata !== 32'hDEAD_BEEF || apb.o_pwrite !== 1'b1) begin n_err++; $display("FAIL wr_bus: got %h/%h/%b want 10/deadbeef/1", apb.o_paddr, apb.o_pwdata, apb.o_pwrite); end
      n_chk++; if (o_ready !== 1'b0) begin n_err++; $display("FAIL wr_ready_busy: got %b want 0", o_ready); end
      apb.i_pready = 1'b1;
      @(negedge clk);
      n_chk++; if ({apb.o_psel, apb.o_penable, o_done} !== 3'b110) begin n_err++; $display("FAIL wr_access: got %b want 110", {apb.o_psel, apb.o_penable, o_done}); end
      @(negedge clk); apb.i_pready = 1'b0;
      n_chk++; if ({o_done, o_err, o_rd_valid} !== 3'b100) begin n_err++; $display("FAIL wr_done: got %b want 100", {o_done, o_err, o_rd_valid}); end
      n_chk++; if ({apb.o_psel, o_ready} !== 2'b01) begin n_err++; $display("FAIL wr_idle: got %b want 01", {apb.o_psel, o_ready}); end
      n_chk++; if (apb.o_paddr !== 32'h10) begin n_err++; $display("FAIL wr_addr_retain: got %h want 10", apb.o_paddr); end
      @(negedge clk);
      n_chk++; if (o_done !== 1'b0) begin n_err++; $display("FAIL wr_done_pulse: got %b want 0", o_done); end
   endtask

   task automatic test_read_wait();
      @(negedge clk); request(32'h0000_0020, 1'b0, 32'hFFFF_FFFF);
      apb.i_prdata = 32'hBAD0_BAD0; apb.i_pslverr = 1'b1;
      @(negedge clk); i_valid = 1'b0;
      n_chk++; if ({apb.o_psel, apb.o_penable, apb.o_pwrite} !== 3'b100) begin n_err++; $display("FAIL rd_setup: got %b want 100", {apb.o_psel, apb.o_penable, apb.o_pwrite}); end
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         n_chk++; if ({apb.o_penable, o_done} !== 2'b10 || apb.o_paddr !== 32'h20) begin n_err++; $display("FAIL rd_wait%0d: got pen/done %b addr %h want 10 addr 20", k, {apb.o_penable, o_done}, apb.o_paddr); end
         if (k == 3) begin apb.i_pready = 1'b1; apb.i_pslverr = 1'b0; apb.i_prdata = 32'h1234_5678; end
      end
      @(negedge clk); apb.i_pready = 1'b0; apb.i_prdata = 32'hBAD0_BAD0;
      n_chk++; if ({o_done, o_rd_valid, o_err} !== 3'b110) begin n_err++; $display("FAIL rd_done: got %b want 110", {o_done, o_rd_valid, o_err}); end
      n_chk++; if (o_rd_data !== 32'h1234_5678) begin n_err++; $display("FAIL rd_data: got %h want 12345678", o_rd_data); end
      @(negedge clk);
      n_chk++; if ({o_done, o_rd_valid} !== 2'b00) begin n_err++; $display("FAIL rd_pulse: got %b want 00", {o_done, o_rd_valid}); end
   endtask

   task automatic test_timeout();
      @(negedge clk); request(32'h0000_0040, 1'b0, 32'h0);
      @(negedge clk); i_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         n_chk++; if ({apb.o_psel, apb.o_penable, o_done} !== 3'b110) begin n_err++; $display("FAIL to_access%0d: got %b want 110", k, {apb.o_psel, apb.o_penable, o_done}); end
      end
      @(negedge clk);
      n_chk++; if ({o_done, o_err, o_rd_valid} !== 3'b111) begin n_err++; $display("FAIL to_done: got %b want 111", {o_done, o_err, o_rd_valid}); end
      n_chk++; if (o_rd_data !== 32'h0) begin n_err++; $display("FAIL to_rd_data: got %h want 0", o_rd_data); end
      n_chk++; if ({apb.o_psel, apb.o_penable} !== 2'b00) begin n_err++; $display("FAIL to_psel: got %b want 00", {apb.o_psel, apb.o_penable}); end
   endtask

   task automatic test_slverr();
      @(negedge clk); request(32'h0000_0030, 1'b1, 32'h0BAD_F00D);
      @(negedge clk); i_valid = 1'b0;
      apb.i_pready = 1'b1; apb.i_pslverr = 1'b1; apb.i_prdata = 32'h5555_AAAA;
      @(negedge clk);
      @(negedge clk); apb.i_pready = 1'b0; apb.i_pslverr = 1'b0;
      n_chk++; if ({o_done, o_err, o_rd_valid} !== 3'b110) begin n_err++; $display("FAIL se_done: got %b want 110", {o_done, o_err, o_rd_valid}); end
      n_chk++; if (o_rd_data !== 32'h0) begin n_err++; $display("FAIL se_rd_data: got %h want 0", o_rd_data); end
      @(negedge clk);
      n_chk++; if ({o_done, o_err} !== 2'b00) begin n_err++; $display("FAIL se_clear: got %b want 00", {o_done, o_err}); end
   endtask

   task automatic test_back_to_back();
      @(negedge clk); request(32'h0000_0050, 1'b1, 32'h1111_1111);
      apb.i_pready = 1'b1;
      @(negedge clk);
      n_chk++; if ({apb.o_psel, apb.o_penable} !== 2'b10 || apb.o_paddr !== 32'h50) begin n_err++; $display("FAIL b2b_setup1: got %b addr %h want 10 addr 50", {apb.o_psel, apb.o_penable}, apb.o_paddr); end
      request(32'h0000_0054, 1'b1, 32'h2222_2222);
      @(negedge clk);
      n_chk++; if (apb.o_paddr !== 32'h50 || apb.o_pwdata !== 32'h1111_1111) begin n_err++; $display("FAIL b2b_hold: got %h/%h want 50/11111111", apb.o_paddr, apb.o_pwdata); end
      @(negedge clk);
      n_chk++; if ({o_done, o_ready} !== 2'b11) begin n_err++; $display("FAIL b2b_done1: got %b want 11", {o_done, o_ready}); end
      @(negedge clk); i_valid = 1'b0;
      n_chk++; if ({apb.o_psel, apb.o_penable, o_done} !== 3'b100 || apb.o_paddr !== 32'h54) begin n_err++; $display("FAIL b2b_setup2: got %b addr %h want 100 addr 54", {apb.o_psel, apb.o_penable, o_done}, apb.o_paddr); end
      @(negedge clk);
      @(negedge clk); apb.i_pready = 1'b0;
      n_chk++; if ({o_done, o_err} !== 2'b10 || apb.o_pwdata !== 32'h2222_2222) begin n_err++; $display("FAIL b2b_done2: got %b data %h want 10 data 22222222", {o_done, o_err}, apb.o_pwdata); end
   endtask

   task automatic test_reset_mid();
      @(negedge clk); request(32'h0000_0060, 1'b0, 32'h0);
      @(negedge clk); i_valid = 1'b0;
      @(negedge clk);
      n_chk++; if (apb.o_penable !== 1'b1) begin n_err++; $display("FAIL rm_access: got %b want 1", apb.o_penable); end
      rst_n = 1'b0;
      #1;
      n_chk++; if ({apb.o_psel, apb.o_penable} !== 2'b00) begin n_err++; $display("FAIL rm_async_drop: got %b want 00", {apb.o_psel, apb.o_penable}); end
      @(negedge clk); rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         n_chk++; if ({o_done, apb.o_psel} !== 2'b00) begin n_err++; $display("FAIL rm_quiet%0d: got %b want 00", k, {o_done, apb.o_psel}); end
      end
      request(32'h0000_0070, 1'b0, 32'h0);
      apb.i_pready = 1'b1; apb.i_prdata = 32'hA5A5_A5A5;
      @(negedge clk); i_valid = 1'b0;
      @(negedge clk);
      @(negedge clk); apb.i_pready = 1'b0;
      n_chk++; if ({o_done, o_rd_valid, o_err} !== 3'b110 || o_rd_data !== 32'hA5A5_A5A5) begin n_err++; $display("FAIL rm_next: got %b data %h want 110 data a5a5a5a5", {o_done, o_rd_valid, o_err}, o_rd_data); end
   endtask

   initial begin
      test_reset();
      test_write_ok();
      test_read_wait();
      test_timeout();
      test_slverr();
      test_back_to_back();
      test_reset_mid();
      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
